// File: rtl/vic_color_fetch_if.sv
// -----------------------------------------------------------------------------
// vic_color_fetch_if
//
// Bundles the colour-fetch control, the shared colour-RAM port and the line
// buffer readout port of vic_color_fetch.
//
//   start      fetch request pulse (to fetcher)
//   vcbase     first colour RAM address of the line (to fetcher)
//   cram_gnt   arbiter grant for the colour RAM (to fetcher)
//   cram_ce    colour RAM read request (from fetcher)
//   cram_ad    colour RAM address (from fetcher)
//   cram_dout  colour RAM read data, 1-cycle latency (to fetcher)
//   busy       fetch in progress (from fetcher)
//   done       one-cycle end-of-line pulse (from fetcher)
//   rd_idx     line buffer column to read (to fetcher)
//   rd_en      line buffer read strobe (to fetcher)
//   color_out  registered line buffer read data (from fetcher)
//
// Modports: slave = the fetcher itself, master = its environment.
// -----------------------------------------------------------------------------
interface vic_color_fetch_if #(
    parameter int AW = 10
);
    logic          start;
    logic [AW-1:0] vcbase;
    logic          cram_gnt;
    logic          cram_ce;
    logic [AW-1:0] cram_ad;
    logic [3:0]    cram_dout;
    logic          busy;
    logic          done;
    logic [5:0]    rd_idx;
    logic          rd_en;
    logic [3:0]    color_out;

    modport slave (
        input  start, vcbase, cram_gnt, cram_dout, rd_idx, rd_en,
        output cram_ce, cram_ad, busy, done, color_out
    );

    modport master (
        output start, vcbase, cram_gnt, cram_dout, rd_idx, rd_en,
        input  cram_ce, cram_ad, busy, done, color_out
    );
endinterface

// File: rtl/vic_color_fetch.sv
// -----------------------------------------------------------------------------
// vic_color_fetch
//
// Colour-RAM reader for the VIC-II video path. On a badline it reads COLS
// consecutive colour nybbles from the shared colour RAM, starting at the
// latched video-counter base, into a COLS-entry line buffer. The character
// display logic then reads the buffer by column for the following raster
// lines.
//
// Parameters:
//   COLS  entries per fetch and line buffer depth (1..64)
//   AW    colour RAM address width
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    vic_color_fetch_if.slave (fetch control, colour RAM port, readout)
//
// A request (cram_ce) is combinational FETCH & cram_gnt, so every granted
// FETCH cycle issues one read. The RAM returns data one cycle after the
// issuing edge, so each issue leaves a pending capture for the next edge;
// back-to-back issues therefore capture back-to-back.
// -----------------------------------------------------------------------------
module vic_color_fetch #(
    parameter int COLS = 40,
    parameter int AW   = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    vic_color_fetch_if.slave     bus
);

    localparam int IW = (COLS > 1) ? $clog2(COLS) : 1;   // buffer index width
    localparam int CW = $clog2(COLS + 1);                 // counts 0..COLS

    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LAST = cnt_t'(COLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } state_t;

    state_t        state, state_next;
    logic [AW-1:0] ptr;
    cnt_t          issue_cnt;
    cnt_t          rx_cnt;
    logic          rx_pend;
    logic [IW-1:0] rx_idx;
    logic          busy_q;
    logic          done_q;
    logic [3:0]    color_q;
    logic [3:0]    line_buf [COLS];

    logic accept;
    logic issue;
    logic last_cap;

    // -------------------------------------------------------------------------
    // Next-state / control decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        last_cap   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.cram_gnt) begin
                    issue = 1'b1;
                    if (issue_cnt == LAST) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The last issue always leaves its capture pending here.
                if (rx_pend && (rx_cnt == LAST)) begin
                    last_cap   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, pointer, counters, line buffer and readout
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            issue_cnt <= '0;
            rx_cnt    <= '0;
            rx_pend   <= 1'b0;
            rx_idx    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            color_q   <= 4'h0;
            // NOTE: the line buffer is cleared on reset so an aborted fetch
            // never leaves stale colours behind; this keeps it in flops
            // rather than a RAM macro, which is acceptable at this depth.
            for (int i = 0; i < COLS; i++) begin
                line_buf[i] <= 4'h0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so the readout below
            // sees the buffer content from before this edge's capture.
            state  <= state_next;
            done_q <= last_cap;

            if (accept) begin
                ptr       <= bus.vcbase;
                issue_cnt <= '0;
                rx_cnt    <= '0;
                busy_q    <= 1'b1;
            end

            if (issue) begin
                ptr       <= ptr + AW'(1);     // wraps modulo 2^AW
                issue_cnt <= issue_cnt + cnt_t'(1);
                rx_idx    <= issue_cnt[IW-1:0];
            end

            // Set by a fresh issue, otherwise cleared by the capture below.
            rx_pend <= issue;

            if (rx_pend) begin
                line_buf[rx_idx] <= bus.cram_dout;
                rx_cnt           <= rx_cnt + cnt_t'(1);
            end

            if (last_cap) begin
                busy_q <= 1'b0;
            end

            if (bus.rd_en) begin
                color_q <= ({1'b0, bus.rd_idx} < 7'(COLS)) ?
                           line_buf[bus.rd_idx[IW-1:0]] : 4'h0;
            end
        end
    end

    assign bus.cram_ce   = (state == ST_FETCH) && bus.cram_gnt;
    assign bus.cram_ad   = ptr;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.color_out = color_q;

endmodule

// File: tb/tb_vic_color_fetch.sv
// -----------------------------------------------------------------------------
// tb_vic_color_fetch
//
// Directed bench for vic_color_fetch. A behavioural 1Kx4 colour RAM with a
// one-cycle registered read answers the fetcher; its contents are a simple
// function of the address and a per-test key, so every expected buffer value
// is computed here from the address alone.
// -----------------------------------------------------------------------------
module tb_vic_color_fetch;

    localparam int AW   = 10;
    localparam int COLS = 40;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    vic_color_fetch_if #(.AW(AW)) ifc ();

    vic_color_fetch #(.COLS(COLS), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    // Colour RAM model: data valid the cycle after the edge that sampled ce.
    logic [3:0] ram [1024];

    always @(posedge clk) begin
        if (ifc.cram_ce) ifc.cram_dout <= ram[ifc.cram_ad];
    end

    // Monitors: issued addresses and done pulses, sampled mid-cycle.
    logic [AW-1:0] addr_q [$];
    int            done_cnt = 0;

    always @(negedge clk) begin
        if (ifc.cram_ce) addr_q.push_back(ifc.cram_ad);
        if (ifc.done)    done_cnt++;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ram_val(input logic [AW-1:0] a, input logic [3:0] key);
        return a[3:0] ^ key;
    endfunction

    task automatic fill_ram(input logic [3:0] key);
        for (int i = 0; i < 1024; i++) ram[i] = ram_val(AW'(i), key);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic read_buf(input int idx, output logic [3:0] v);
        tick;
        ifc.rd_en  = 1'b1;
        ifc.rd_idx = 6'(idx);
        tick;
        ifc.rd_en  = 1'b0;
        @(negedge clk);
        v = ifc.color_out;
    endtask

    // One complete line fetch. Cycle j is the cycle after edge E_j (E0 = the
    // edge that accepts start); the grant driven in cycle j decides the issue
    // at E_{j+1}.
    task automatic run_fetch(input logic [AW-1:0] base, input logic [3:0] key,
                             input bit stall, input bit extra_starts,
                             input bit coll, input logic [3:0] old7);
        int            q0, d0, lat, model_iss, lows;
        logic [3:0]    v;
        logic [AW-1:0] ea;

        fill_ram(key);
        q0 = addr_q.size();
        d0 = done_cnt;

        tick;
        ifc.start    = 1'b1;
        ifc.vcbase   = base;
        ifc.cram_gnt = 1'b1;
        tick;
        ifc.start  = 1'b0;
        ifc.vcbase = 10'h2D5;       // must not matter once latched

        lat       = -1;
        model_iss = 0;
        lows      = 0;
        for (int j = 0; j < 200 && lat < 0; j++) begin
            ifc.cram_gnt = stall ? (j % 3 != 2) : 1'b1;
            if (model_iss < COLS) begin
                if (ifc.cram_gnt) model_iss++;
                else              lows++;
            end
            ifc.start = 1'b0;
            if (extra_starts && j == 10) begin
                ifc.start  = 1'b1;
                ifc.vcbase = 10'h155;
            end
            if (extra_starts && j == COLS) begin   // sampled on the done edge
                ifc.start  = 1'b1;
                ifc.vcbase = 10'h0AA;
            end
            ifc.rd_en  = coll && (j == 8);          // sampled on buf[7]'s capture edge
            ifc.rd_idx = 6'd7;
            @(negedge clk);
            if (coll && j == 9) check("collision_old", 32'(ifc.color_out), 32'(old7));
            if (ifc.done) lat = j;
            else          tick;
        end
        tick;
        ifc.start    = 1'b0;
        ifc.rd_en    = 1'b0;
        ifc.cram_gnt = 1'b1;

        check("latency", 32'(lat), 32'(COLS + 1 + lows));
        repeat (10) tick;
        @(negedge clk);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("issue_count", 32'(addr_q.size() - q0), 32'(COLS));
        check("busy_after", 32'(ifc.busy), 32'd0);

        for (int i = 0; i < COLS && (q0 + i) < addr_q.size(); i++) begin
            ea = base + AW'(i);
            check($sformatf("addr[%0d]", i), 32'(addr_q[q0 + i]), 32'(ea));
        end
        for (int i = 0; i < COLS; i++) begin
            ea = base + AW'(i);
            read_buf(i, v);
            check($sformatf("buf[%0d]", i), 32'(v), 32'(ram_val(ea, key)));
        end
    endtask

    initial begin
        logic [3:0] v;
        int         d0;

        reset        = 1'b1;
        ifc.start    = 1'b0;
        ifc.vcbase   = '0;
        ifc.cram_gnt = 1'b1;
        ifc.rd_en    = 1'b0;
        ifc.rd_idx   = '0;
        ifc.cram_dout = 4'h0;

        // Reset state
        repeat (3) tick;
        @(negedge clk);
        check("rst_busy",    32'(ifc.busy),      32'd0);
        check("rst_done",    32'(ifc.done),      32'd0);
        check("rst_cram_ce", 32'(ifc.cram_ce),   32'd0);
        check("rst_cram_ad", 32'(ifc.cram_ad),   32'd0);
        check("rst_color",   32'(ifc.color_out), 32'd0);
        tick;
        reset = 1'b0;

        // Continuous grant, RAM[a] = a[3:0]
        run_fetch(10'h100, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        read_buf(5, v);
        check("t1_rd5", 32'(v), 32'h5);

        // Address wrap 0x3FF -> 0x000
        run_fetch(10'h3F0, 4'hA, 1'b0, 1'b0, 1'b0, 4'h0);
        read_buf(16, v);
        check("t2_buf16", 32'(v), 32'(ram_val(10'h000, 4'hA)));

        // Grant low every third FETCH cycle
        run_fetch(10'h0C3, 4'h5, 1'b1, 1'b0, 1'b0, 4'h0);

        // Starts mid-fetch and on the done edge are ignored
        run_fetch(10'h280, 4'h3, 1'b0, 1'b1, 1'b0, 4'h0);

        // Read/write collision on buf[7]: prior content is 0x287[3:0]^3 = 4
        run_fetch(10'h300, 4'hC, 1'b0, 1'b0, 1'b1, 4'h4);
        read_buf(45, v);
        check("rd_out_of_range", 32'(v), 32'h0);

        // Reset after 20 issues
        fill_ram(4'h6);
        d0 = done_cnt;
        tick;
        ifc.start  = 1'b1;
        ifc.vcbase = 10'h200;
        tick;
        ifc.start = 1'b0;
        for (int j = 0; j < 20; j++) begin
            ifc.rd_en  = (j == 2);
            ifc.rd_idx = 6'd39;
            @(negedge clk);
            // buf[39] from the previous line: 0x327[3:0]^C = 0xB
            if (j == 3) check("pre_rst_rd39", 32'(ifc.color_out), 32'hB);
            tick;
        end
        ifc.rd_en = 1'b0;
        reset     = 1'b1;
        tick;
        @(negedge clk);
        check("midrst_busy",    32'(ifc.busy),      32'd0);
        check("midrst_cram_ce", 32'(ifc.cram_ce),   32'd0);
        check("midrst_color",   32'(ifc.color_out), 32'd0);
        tick;
        reset = 1'b0;
        read_buf(3, v);
        check("midrst_rd3", 32'(v), 32'h0);
        repeat (50) tick;
        check("midrst_no_done", 32'(done_cnt - d0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vic_color_fetch.md
# vic_color_fetch

Color-RAM reader for the VIC-II video path. On each badline it fetches 40 consecutive color nybbles from the 1K×4 color RAM, starting at the latched video-counter base, and stores them in an internal 40-entry line buffer. The character-display logic then reads the buffer by column index for the following eight raster lines. It sits between the shared color RAM port, which is arbitrated against the CPU, and the VIC pixel sequencer.

## Interface
Parameters:
- COLS, 40, number of entries per fetch and buffer depth (1..64)
- AW, 10, color RAM address width

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that begins a line fetch; ignored while busy
- vcbase  in  AW  first color RAM address of the line; latched on an accepted start
- cram_gnt  in  1  arbiter grant; VIC may access color RAM this cycle
- cram_ce  out  1  color RAM clock enable (read request); combinational = FETCH & cram_gnt
- cram_ad  out  AW  color RAM address; registered
- cram_dout  in  4  color RAM read data, valid in the cycle after the edge that sampled cram_ce
- busy  out  1  high from the accepted start until the last capture
- done  out  1  one-cycle pulse after the last entry has been written to the buffer
- rd_idx  in  6  buffer column to read
- rd_en  in  1  read strobe
- color_out  out  4  registered buffer read data

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: when start=1, latch vcbase into ptr, clear issue_cnt and rx_cnt, set busy, and go to FETCH.
- FETCH: every edge with cram_ce=1 is an issue:
  - ptr increments, wrapping modulo 2^AW (for example, 0x3FF goes to 0x000).
  - issue_cnt increments.
  - rx_pend is set and rx_idx is set to issue_cnt.
  - When the COLS-th issue occurs, go to DRAIN.
- Capture: on any edge where rx_pend=1, write buf[rx_idx] <= cram_dout and increment rx_cnt. rx_pend clears unless a new issue occurs on the same edge. Back-to-back issues therefore capture back-to-back.
- DRAIN: on the final capture edge, busy goes to 0, done goes to 1 for one cycle, and the state returns to IDLE.
- When cram_gnt=0 during FETCH, no issue occurs and ptr and issue_cnt hold. A pending capture still completes.
- Readout, independent of state:
  - On an edge with rd_en=1, color_out <= buf[rd_idx], or 0 if rd_idx ≥ COLS.
  - With rd_en=0, color_out holds.
- Simultaneous readout and capture to the same index: color_out gets the old content (read-before-write).
- A start during busy is ignored, and vcbase is not re-latched.
- A start on the same edge as done (the DRAIN exit) is ignored. A start is accepted only in IDLE.
- Reset values:
  - state=IDLE, busy=0, done=0, cram_ad=0, ptr=0, issue_cnt=0, rx_cnt=0, rx_pend=0, color_out=0.
  - All buf entries are 0.
  - cram_ce=0 follows from the state.
- Reset mid-fetch aborts immediately. No done pulse is produced and buf is cleared.

## Timing
- start sampled at edge E0. FETCH is active from E0. With continuous grant:
  - Issues occur at edges E1..E40, with cram_ad = vcbase+0 .. vcbase+39 during cycles E0..E39.
  - Captures occur at E2..E41.
  - done is high in cycle E41..E42; busy is low after E41.
- Total latency from start to done with no grant stalls: 41 cycles, plus 1 cycle for each cycle cram_gnt=0 in FETCH.
- Readout latency: 1 cycle from rd_en to color_out.
- The RAM's output register enable is held at 1 by the top level, so its read latency is 1 cycle.

## Test plan
- Continuous grant:
  - Stimulus: preload RAM[a] = a[3:0], start with vcbase=0x100.
  - Required: cram_ad steps 0x100..0x127, done arrives exactly 41 cycles after start, and rd_idx=5 returns 0x5.
- Address wrap:
  - Stimulus: vcbase=0x3F0.
  - Required: addresses run 0x3F0..0x3FF then 0x000..0x017, buf[16] = RAM[0x000], and done is still a single pulse.
- Grant stalls:
  - Stimulus: cram_gnt low on every third cycle during FETCH.
  - Required: no address is skipped or repeated, buf matches RAM, and done is delayed exactly by the count of low-grant FETCH cycles.
- Ignored start:
  - Stimulus: a second start with a different vcbase in mid-fetch, and another on the done edge.
  - Required: the fetch continues from the original base and no extra fetch occurs.
- Reset mid-fetch:
  - Stimulus: assert reset after 20 issues.
  - Required: next cycle busy=0, cram_ce=0, color_out=0, rd_idx=3 reads 0, and done never pulses.
- Read/write collision and out-of-range read:
  - Stimulus: rd_en with rd_idx=7 on buf[7]'s capture edge; then rd_idx=45.
  - Required: the first read returns the prior value of buf[7]; rd_idx=45 returns 0.
